spi_master: RTL and testbench
=============================

# spi_master

Memory-mapped SPI master (mode 0, 16-bit frames, MSB first) for the CPU bus. It is the initiator counterpart of the SoC's SPI slave peripheral. The CPU writes a 16-bit word to DATA, which starts a frame. The block drives CS, SCLK and MOSI, captures MISO, and posts the received word plus a done flag in STATUS. Everything runs in one clock domain, and the bus handshake is identical to the other bus peripherals.

## Interface
- Parameters: none. The frame width is fixed at 16 bits.
- `clk` in 1: system clock. All logic is on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `pin_mosi` out 1: serial data to the slave.
- `pin_clk` out 1: SCLK, idles low.
- `pin_cs` out 1: chip select, active low, idles high.
- `pin_miso` in 1: serial data from the slave. It is registered on use; no extra synchroniser is needed at the divider limits below.
- `address_in` in 32: bus address. Bits [3:2] select the register.
- `sel_in` in 1: peripheral select.
- `read_in` in 1: read strobe.
- `read_value_out` out 32: combinational read data. It is 0 when `sel_in`=0.
- `write_mask_in` in 4: byte enables.
- `write_value_in` in 32: write data.
- `ready_out` out 1: equal to `sel_in`, giving zero-wait access.

## Operation
- Registers are selected by `address_in[3:2]`:
  - DATA (00)
    - Read returns `{16'b0, rx}`.
    - A write with `write_mask_in[1:0]`=11 loads tx=`write_value_in[15:0]` and starts a frame if idle.
  - STATUS (01)
    - Read returns `{29'b0, ovr, done, busy}`.
    - Writing 1 to bit2 clears ovr, provided `write_mask_in[0]`=1.
  - CTRL (10)
    - Read returns `{24'b0, div}`.
    - A write with `write_mask_in[0]` sets div=`write_value_in[7:0]`.
    - A write while busy takes effect at the next frame start.
  - Address 11: reads return 0 and writes are ignored.
- Half-period H = div+1 clk cycles. div resets to 3, so H=4. Interoperating with the SoC SPI slave requires H≥4.
- FSM states: IDLE, SETUP, HIGH, LOW, GAP.
  - IDLE
    - A DATA write goes to SETUP.
    - `pin_cs`=0 and `pin_mosi`=tx[15] from the next cycle.
    - busy=1, bit count=0, and div is latched for the frame.
  - SETUP: lasts H cycles, then goes to HIGH.
  - HIGH
    - On entry, `pin_clk`=1 and `pin_miso` is shifted into the rx shift register LSB.
    - Lasts H cycles, then goes to LOW.
  - LOW
    - On entry, `pin_clk`=0 and `pin_mosi` takes the next tx bit.
    - Lasts H cycles.
    - If the count is below 15, the count increments and the FSM returns to HIGH.
    - After the 16th LOW phase the FSM goes to GAP.
  - GAP
    - On entry, `pin_cs`=1, rx is updated from the shift register, and done=1.
    - Lasts H cycles, then goes to IDLE with busy=0.
- MOSI changes only on SCLK falling edges (and at frame start). MISO is sampled on SCLK rising edges.
- done is sticky.
  - It is cleared by a DATA read (`sel_in`&`read_in`, address 00).
  - If a clear and frame completion coincide, done=1.
  - A new frame start does not clear done.
- A DATA write while busy is ignored and sets ovr (sticky). tx and the frame in flight are unaffected.
- `pin_mosi` holds its last bit after a frame ends.

## Timing
- Reset values:
  - `pin_cs`=1, `pin_clk`=0, `pin_mosi`=0.
  - tx=0, rx=0, div=3.
  - busy=0, done=0, ovr=0, state IDLE.
- Frame timing, for a DATA write sampled at edge T:
  - busy and `pin_cs`=0 are visible at T+1.
  - The first SCLK rise is at T+1+H.
  - The k-th rise (k=1..16) is at T+1+(2k−1)H.
  - CS deasserts, done sets and rx updates at T+1+33H.
  - busy clears at T+1+34H, so busy is high for exactly 34H cycles.
- The earliest next frame start is the write at T+1+34H. CS-high gap ≥ H+1 cycles.
- Reset mid-frame returns all state to reset values at the next edge. CS rises immediately and no done is posted.

## Structure
- Shared package `spi_pkg`:
  - Register offsets `SPI_DATA`=2'b00, `SPI_STATUS`=2'b01, `SPI_CTRL`=2'b10, also used by the slave.
  - The state enum `spi_master_state_t`.
  - STATUS bit indices.
- Sub-module `spi_tick_gen`:
  - 8-bit down-counter, reloaded with div.
  - Emits a one-cycle tick every H cycles while enabled.
  - Restarts on enable rising.
- The FSM advances only on ticks.

## Test plan
- Reset: after reset, STATUS reads 0, CTRL reads 3, `pin_cs`=1, `pin_clk`=0.
- Loopback: `pin_miso` tied to `pin_mosi`, div=0, write DATA 0xA5C3.
  - busy is high for 34 cycles.
  - Exactly 16 SCLK pulses.
  - done=1, and DATA reads 0xA5C3.
- Behavioural slave model, div=3:
  - Master sends 0xBEEF while the model returns 0x1234.
  - The model captures 0xBEEF and rx=0x1234.
  - SCLK high and low phases are each 4 cycles.
- Overrun: a second DATA write of 0x0001 mid-frame gives ovr=1, and the first frame's MOSI bits are unchanged. Writing STATUS bit2 clears ovr.
- Reset asserted after the 5th SCLK rise: `pin_cs`=1 next cycle, rx=0, done=0. A subsequent frame completes normally.
- DATA read in the same cycle CS deasserts: done stays 1. A following read clears it.

Source files
------------

// File: rtl/spi_pkg.sv
// spi_pkg: register map, status bit positions and master FSM states shared by the SPI blocks
package spi_pkg;
  localparam logic [1:0] SPI_DATA   = 2'b00;
  localparam logic [1:0] SPI_STATUS = 2'b01;
  localparam logic [1:0] SPI_CTRL   = 2'b10;
  localparam int ST_BUSY = 0;
  localparam int ST_DONE = 1;
  localparam int ST_OVR  = 2;
  localparam logic [7:0] DIV_RESET = 8'd3;
  localparam logic [3:0] LAST_BIT = 4'd15;
  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_HIGH, S_LOW, S_GAP} spi_master_state_t;
endpackage

// File: rtl/spi_tick_gen.sv
// spi_tick_gen: one-cycle tick every div+1 cycles while enabled, phase restarted on enable rise
module spi_tick_gen (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_en,
  input  logic [7:0] i_div,
  output logic       o_tick
);
  logic [7:0] r_cnt;
  logic       r_en_d;
  logic [7:0] w_cnt;
  assign w_cnt  = (i_en && !r_en_d) ? i_div : r_cnt;
  assign o_tick = i_en && (w_cnt == 8'd0);
  // down-counter reloaded after each tick so ticks land every div+1 cycles
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt  <= 8'd0;
      r_en_d <= 1'b0;
    end else begin
      r_en_d <= i_en;
      r_cnt  <= o_tick ? i_div : w_cnt - 8'd1;
    end
  end
endmodule

// File: rtl/spi_master.sv
// spi_master: memory-mapped mode-0 SPI master, 16-bit MSB-first frames
module spi_master
  import spi_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  output logic        pin_mosi,
  output logic        pin_clk,
  output logic        pin_cs,
  input  logic        pin_miso,
  input  logic [31:0] address_in,
  input  logic        sel_in,
  input  logic        read_in,
  output logic [31:0] read_value_out,
  input  logic [3:0]  write_mask_in,
  input  logic [31:0] write_value_in,
  output logic        ready_out
);
  spi_master_state_t r_state;
  logic [15:0] r_tx;
  logic [15:0] r_rx;
  logic [15:0] r_sh;
  logic [7:0]  r_div;
  logic [7:0]  r_div_f;
  logic [3:0]  r_bit;
  logic        r_busy;
  logic        r_done;
  logic        r_ovr;
  logic [1:0]  w_reg;
  logic        w_data_wr;
  logic        w_data_rd;
  logic        w_ovr_clr;
  logic        w_ctrl_wr;
  logic        w_tick;
  logic        w_frame_end;
  logic [3:0]  w_idx;
  logic        w_unused;
  assign w_reg       = address_in[3:2];
  assign w_data_wr   = sel_in && w_reg == SPI_DATA && write_mask_in[1:0] == 2'b11;
  assign w_data_rd   = sel_in && read_in && w_reg == SPI_DATA;
  assign w_ovr_clr   = sel_in && w_reg == SPI_STATUS && write_mask_in[0] && write_value_in[ST_OVR];
  assign w_ctrl_wr   = sel_in && w_reg == SPI_CTRL && write_mask_in[0];
  assign w_frame_end = w_tick && r_state == S_LOW && r_bit == LAST_BIT;
  assign w_idx       = 4'd14 - r_bit;
  assign ready_out   = sel_in;
  assign w_unused    = ^{address_in[31:4], address_in[1:0], write_mask_in[3:2], write_value_in[31:16]};
  spi_tick_gen u_tick (
    .clk   (clk),
    .reset (reset),
    .i_en  (r_busy),
    .i_div (r_div_f),
    .o_tick(w_tick)
  );
  // bus read mux, zero when not selected
  always_comb begin
    read_value_out = !sel_in                ? 32'd0 :
                     w_reg == SPI_DATA      ? {16'd0, r_rx} :
                     w_reg == SPI_STATUS    ? {29'd0, r_ovr, r_done, r_busy} :
                     w_reg == SPI_CTRL      ? {24'd0, r_div} : 32'd0;
  end
  // sticky done/overrun flags and the divider register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_done <= 1'b0;
      r_ovr  <= 1'b0;
      r_div  <= DIV_RESET;
    end else begin
      r_done <= w_frame_end | (r_done & ~w_data_rd);
      r_ovr  <= (w_data_wr & r_busy) | (r_ovr & ~w_ovr_clr);
      r_div  <= w_ctrl_wr ? write_value_in[7:0] : r_div;
    end
  end
  // frame sequencer: every phase lasts one tick period, pins are registered here
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_tx     <= 16'd0;
      r_rx     <= 16'd0;
      r_sh     <= 16'd0;
      r_div_f  <= DIV_RESET;
      r_bit    <= 4'd0;
      r_busy   <= 1'b0;
      pin_cs   <= 1'b1;
      pin_clk  <= 1'b0;
      pin_mosi <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (w_data_wr) begin
          r_state  <= S_SETUP;
          r_tx     <= write_value_in[15:0];
          r_div_f  <= r_div;
          r_bit    <= 4'd0;
          r_busy   <= 1'b1;
          pin_cs   <= 1'b0;
          pin_mosi <= write_value_in[15];
        end
        S_SETUP: if (w_tick) begin
          r_state <= S_HIGH;
          pin_clk <= 1'b1;
          r_sh    <= {r_sh[14:0], pin_miso};
        end
        S_HIGH: if (w_tick) begin
          r_state  <= S_LOW;
          pin_clk  <= 1'b0;
          pin_mosi <= r_bit == LAST_BIT ? pin_mosi : r_tx[w_idx];
        end
        S_LOW: if (w_tick) begin
          if (r_bit == LAST_BIT) begin
            r_state <= S_GAP;
            pin_cs  <= 1'b1;
            r_rx    <= r_sh;
          end else begin
            r_state <= S_HIGH;
            r_bit   <= r_bit + 4'd1;
            pin_clk <= 1'b1;
            r_sh    <= {r_sh[14:0], pin_miso};
          end
        end
        S_GAP: if (w_tick) begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: time-based frame model plus directed and randomized bus traffic
module tb_spi_master;
  logic        clk = 0;
  logic        reset = 1;
  logic        pin_mosi, pin_clk, pin_cs, pin_miso;
  logic [31:0] address_in = 0;
  logic        sel_in = 0;
  logic        read_in = 0;
  logic [31:0] read_value_out;
  logic [3:0]  write_mask_in = 0;
  logic [31:0] write_value_in = 0;
  logic        ready_out;
  int total = 0;
  int bad = 0;
  int mode = 1;
  logic rnd_bit = 0;
  logic [15:0] s_word = 0;
  logic [15:0] s_cap = 0;
  int s_idx = 15;
  logic p_cs = 1;
  logic p_clk = 0;

  spi_master dut (
    .clk(clk), .reset(reset), .pin_mosi(pin_mosi), .pin_clk(pin_clk), .pin_cs(pin_cs),
    .pin_miso(pin_miso), .address_in(address_in), .sel_in(sel_in), .read_in(read_in),
    .read_value_out(read_value_out), .write_mask_in(write_mask_in),
    .write_value_in(write_value_in), .ready_out(ready_out)
  );

  always #5 clk = ~clk;

  assign pin_miso = mode == 0 ? pin_mosi : mode == 1 ? s_word[s_idx[3:0]] : rnd_bit;
  always @(negedge clk) rnd_bit = 1'($urandom_range(0, 1));

  // mode-0 slave: present MSB on CS fall, shift out on SCLK fall, capture MOSI on SCLK rise
  always @(pin_cs or pin_clk) begin
    if (p_cs && pin_cs === 1'b0) s_idx = 15;
    else if (pin_cs === 1'b0 && p_clk && pin_clk === 1'b0 && s_idx > 0) s_idx--;
    if (pin_cs === 1'b0 && !p_clk && pin_clk === 1'b1) s_cap = {s_cap[14:0], pin_mosi};
    p_cs = (pin_cs !== 1'b0);
    p_clk = (pin_clk === 1'b1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model: outputs derived from cycles elapsed since the frame became visible
  bit m_on = 0, m_act = 0, m_done = 0, m_ovr = 0;
  int m_n = 0, m_h = 4;
  logic [15:0] m_tx = 0, m_rx = 0, m_sh = 0;
  logic [7:0] m_div = 3;
  logic m_idle_mosi = 0;
  always @(posedge clk) begin : model
    logic [1:0] a;
    logic wr_d, rd_d, wb, e_cs, e_clk, e_mosi;
    logic [31:0] e_rd;
    int j;
    a = address_in[3:2];
    if (reset) begin
      m_on = 1; m_act = 0; m_done = 0; m_ovr = 0; m_rx = 0; m_div = 3; m_tx = 0; m_idle_mosi = 0;
    end else begin
      wr_d = sel_in && a == 2'd0 && write_mask_in[1:0] == 2'b11;
      rd_d = sel_in && read_in && a == 2'd0;
      wb = m_act;
      if (rd_d) m_done = 0;
      if (m_act) begin
        m_n++;
        if (m_n < 33 * m_h && m_n % m_h == 0 && (m_n / m_h) % 2 == 1) m_sh = {m_sh[14:0], pin_miso};
        if (m_n == 33 * m_h) begin m_done = 1; m_rx = m_sh; m_idle_mosi = m_tx[0]; end
        if (m_n == 34 * m_h) m_act = 0;
      end
      if (wr_d) begin
        if (wb) m_ovr = 1;
        else begin m_act = 1; m_n = 0; m_h = int'(m_div) + 1; m_tx = write_value_in[15:0]; end
      end
      if (sel_in && a == 2'd1 && write_mask_in[0] && write_value_in[2]) m_ovr = 0;
      if (sel_in && a == 2'd2 && write_mask_in[0]) m_div = write_value_in[7:0];
    end
    #1;
    if (m_on) begin
      a = address_in[3:2];
      e_cs = !(m_act && m_n < 33 * m_h);
      e_clk = m_act && m_n >= m_h && m_n < 33 * m_h && (m_n / m_h) % 2 == 1;
      j = m_n / (2 * m_h);
      if (j > 15) j = 15;
      e_mosi = (m_act && m_n < 33 * m_h) ? m_tx[15 - j] : m_idle_mosi;
      e_rd = !sel_in ? 32'd0 : a == 2'd0 ? {16'd0, m_rx} :
             a == 2'd1 ? {29'd0, m_ovr, m_done, m_act} : a == 2'd2 ? {24'd0, m_div} : 32'd0;
      chk("cs", 32'(pin_cs), 32'(e_cs));
      chk("sclk", 32'(pin_clk), 32'(e_clk));
      chk("mosi", 32'(pin_mosi), 32'(e_mosi));
      chk("rdata", read_value_out, e_rd);
      chk("ready", 32'(ready_out), 32'(sel_in));
    end
  end

  // SCLK monitor: rise count and phase lengths while CS is low
  int mon_rises = 0, hi_min = 999, hi_max = 0, lo_min = 999, lo_max = 0, run = 0;
  logic mon_prev = 0;
  always @(posedge clk) begin
    #1;
    if (pin_cs !== 1'b0) run = 0;
    else if (pin_clk !== mon_prev) begin
      if (run > 0) begin
        if (mon_prev) begin hi_min = run < hi_min ? run : hi_min; hi_max = run > hi_max ? run : hi_max; end
        else begin lo_min = run < lo_min ? run : lo_min; lo_max = run > lo_max ? run : lo_max; end
      end
      run = 1;
      if (pin_clk === 1'b1) mon_rises++;
    end else run++;
    mon_prev = (pin_clk === 1'b1);
  end

  task automatic mon_clear();
    mon_rises = 0; hi_min = 999; hi_max = 0; lo_min = 999; lo_max = 0;
  endtask

  task automatic bus_write(input logic [1:0] r, input logic [31:0] v, input logic [3:0] m);
    @(negedge clk);
    sel_in = 1; read_in = 0; address_in = {28'd0, r, 2'b00}; write_value_in = v; write_mask_in = m;
    @(negedge clk);
    sel_in = 0; write_mask_in = 0;
  endtask

  task automatic bus_read(input logic [1:0] r, output logic [31:0] v);
    @(negedge clk);
    sel_in = 1; read_in = 1; address_in = {28'd0, r, 2'b00}; write_mask_in = 0;
    #1 v = read_value_out;
    @(negedge clk);
    sel_in = 0; read_in = 0;
  endtask

  task automatic wait_idle();
    logic [31:0] v;
    bit ok = 0;
    for (int i = 0; i < 400; i++) begin
      bus_read(2'd1, v);
      if (!v[0]) begin ok = 1; break; end
    end
    total++;
    if (!ok) begin bad++; $display("FAIL idle_wait: busy 1 want 0"); end
  endtask

  initial begin
    logic [31:0] v;
    int cnt, op;
    repeat (3) @(negedge clk);
    reset = 0;
    bus_read(2'd1, v); chk("rst_status", v, 32'h0);
    bus_read(2'd2, v); chk("rst_ctrl", v, 32'h3);
    chk("rst_cs", 32'(pin_cs), 32'h1);
    chk("rst_sclk", 32'(pin_clk), 32'h0);

    mode = 0;
    bus_write(2'd2, 32'h0, 4'h1);
    mon_clear();
    bus_write(2'd0, 32'hA5C3, 4'h3);
    sel_in = 1; read_in = 0; address_in = 32'h4; write_mask_in = 0;
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (read_value_out[0]) cnt++; else break;
      @(negedge clk);
    end
    sel_in = 0;
    chk("loop_busy_len", cnt, 34);
    chk("loop_rises", mon_rises, 16);
    bus_read(2'd1, v); chk("loop_done", v, 32'h2);
    bus_read(2'd0, v); chk("loop_rx", v, 32'hA5C3);
    bus_read(2'd1, v); chk("loop_done_clr", v, 32'h0);

    mode = 1; s_word = 16'h1234;
    bus_write(2'd2, 32'h3, 4'h1);
    mon_clear();
    bus_write(2'd0, 32'hBEEF, 4'h3);
    wait_idle();
    chk("slv_cap", 32'(s_cap), 32'hBEEF);
    bus_read(2'd0, v); chk("slv_rx", v, 32'h1234);
    chk("slv_rises", mon_rises, 16);
    chk("slv_hi_min", hi_min, 4); chk("slv_hi_max", hi_max, 4);
    chk("slv_lo_min", lo_min, 4); chk("slv_lo_max", lo_max, 4);

    bus_write(2'd0, 32'h5A5A, 4'h3);
    repeat (20) @(negedge clk);
    bus_write(2'd0, 32'h0001, 4'hF);
    bus_read(2'd1, v); chk("ovr_set", v, 32'h5);
    wait_idle();
    chk("ovr_cap", 32'(s_cap), 32'h5A5A);
    bus_write(2'd1, 32'h4, 4'h1);
    bus_read(2'd1, v); chk("ovr_clr", v, 32'h2);
    bus_read(2'd0, v); chk("ovr_rx", v, 32'h1234);

    s_word = 16'h0F0F;
    mon_clear();
    bus_write(2'd0, 32'hABCD, 4'h3);
    for (int i = 0; i < 300 && mon_rises < 5; i++) @(negedge clk);
    chk("rst_mid_rises", mon_rises, 5);
    reset = 1;
    @(negedge clk);
    reset = 0;
    chk("rst_mid_cs", 32'(pin_cs), 32'h1);
    bus_read(2'd1, v); chk("rst_mid_status", v, 32'h0);
    bus_read(2'd0, v); chk("rst_mid_rx", v, 32'h0);
    s_word = 16'h3C3C;
    bus_write(2'd0, 32'h1357, 4'h3);
    wait_idle();
    chk("post_rst_cap", 32'(s_cap), 32'h1357);
    bus_read(2'd0, v); chk("post_rst_rx", v, 32'h3C3C);

    s_word = 16'h8001;
    bus_write(2'd0, 32'h7E7E, 4'h3);
    repeat (33 * 4 - 2) @(negedge clk);
    bus_read(2'd0, v);
    bus_read(2'd1, v); chk("coin_done", v, 32'h3);
    wait_idle();
    bus_read(2'd0, v); chk("coin_rx", v, 32'h8001);
    bus_read(2'd1, v); chk("coin_clr", v, 32'h0);

    for (int f = 0; f < 6; f++) begin
      mode = (f % 2 == 0) ? 2 : 1;
      s_word = 16'($urandom);
      bus_write(2'd2, 32'($urandom_range(0, 3)), 4'h1);
      bus_write(2'd0, $urandom, 4'h3);
      for (int k = 0; k < 30; k++) begin
        op = $urandom_range(0, 6);
        case (op)
          0: @(negedge clk);
          1: bus_read(2'd1, v);
          2: bus_write(2'd0, $urandom, 4'hF);
          3: bus_write(2'd1, 32'h4, 4'h1);
          4: bus_write(2'd2, 32'($urandom_range(0, 3)), 4'h1);
          5: bus_write(2'd0, $urandom, 4'h1);
          default: bus_read(2'd0, v);
        endcase
      end
      wait_idle();
    end
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
